// File: rtl/ddr4_cmd_sched_if.sv
// ddr4_cmd_sched_if: request handshake and DIMM command pins of the DDR4 command scheduler
interface ddr4_cmd_sched_if #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [BGWIDTH-1:0]   req_bg;
  logic [BAWIDTH-1:0]   req_ba;
  logic [ADDRWIDTH-1:0] req_row;
  logic [COLWIDTH-1:0]  req_col;
  logic                 stall;
  logic                 cs_n;
  logic                 act_n;
  logic [ADDRWIDTH-1:0] A;
  logic [BGWIDTH-1:0]   bg;
  logic [BAWIDTH-1:0]   ba;
  logic                 cmd_done;
  logic                 busy;
  modport master (
    output req_valid, req_we, req_bg, req_ba, req_row, req_col, stall,
    input  req_ready, cs_n, act_n, A, bg, ba, cmd_done, busy
  );
  modport slave (
    input  req_valid, req_we, req_bg, req_ba, req_row, req_col, stall,
    output req_ready, cs_n, act_n, A, bg, ba, cmd_done, busy
  );
endinterface

// File: rtl/ddr4_cmd_sched.sv
// ddr4_cmd_sched: open-page DDR4 command scheduler with per-bank row tracking and periodic refresh
module ddr4_cmd_sched #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int TRCD      = 4,
  parameter int TRP       = 4,
  parameter int TRAS      = 10,
  parameter int TCCD      = 4,
  parameter int TRFC      = 30,
  parameter int TREFI     = 200
) (
  input logic              clk,
  input logic              reset_n,
  ddr4_cmd_sched_if.slave  bus
);
  localparam int BW   = BGWIDTH + BAWIDTH;
  localparam int NB   = 2 ** BW;
  localparam int WMAX = TRFC > TRP ? (TRFC > TRCD ? TRFC : TRCD) : (TRP > TRCD ? TRP : TRCD);
  localparam int WW   = $clog2(WMAX + 1);
  localparam int RW   = $clog2(TRAS + 1);
  localparam int CW   = $clog2(TCCD + 1);
  localparam int FW   = $clog2(TREFI + 1);
  localparam logic [ADDRWIDTH-1:0] ONE    = ADDRWIDTH'(1);
  localparam logic [ADDRWIDTH-1:0] A_RD   = (ONE << 16) | (ONE << 14);
  localparam logic [ADDRWIDTH-1:0] A_WR   = ONE << 16;
  localparam logic [ADDRWIDTH-1:0] A_PRE  = ONE << 15;
  localparam logic [ADDRWIDTH-1:0] A_PREA = (ONE << 15) | (ONE << 10);
  localparam logic [ADDRWIDTH-1:0] A_REF  = ONE << 14;
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PRE      = 4'd1;
  localparam logic [3:0] S_WAIT_RP  = 4'd2;
  localparam logic [3:0] S_ACT      = 4'd3;
  localparam logic [3:0] S_WAIT_RCD = 4'd4;
  localparam logic [3:0] S_COL      = 4'd5;
  localparam logic [3:0] S_RPREA    = 4'd6;
  localparam logic [3:0] S_RWAIT_RP = 4'd7;
  localparam logic [3:0] S_RREF     = 4'd8;
  localparam logic [3:0] S_WAIT_RFC = 4'd9;
  logic [3:0]           state;
  logic [WW-1:0]        wait_cnt;
  logic [CW-1:0]        ccd_cnt;
  logic [FW-1:0]        ref_cnt;
  logic                 ref_pending;
  logic                 run;
  logic [NB-1:0]        open_bank;
  logic [ADDRWIDTH-1:0] row_tab [NB];
  logic [RW-1:0]        tras [NB];
  logic                 r_we;
  logic [BGWIDTH-1:0]   r_bg;
  logic [BAWIDTH-1:0]   r_ba;
  logic [ADDRWIDTH-1:0] r_row;
  logic [COLWIDTH-1:0]  r_col;
  logic [BW-1:0]        bk;
  logic [BW-1:0]        rbk;
  logic                 accept;
  logic                 tras_clr;
  assign bk            = {r_bg, r_ba};
  assign rbk           = {bus.req_bg, bus.req_ba};
  // run keeps req_ready low while reset_n is held and for the release cycle
  assign bus.req_ready = run && state == S_IDLE && !ref_pending && !bus.stall;
  assign bus.busy      = state != S_IDLE || ref_pending;
  assign accept        = bus.req_valid && bus.req_ready;
  always_comb begin
    tras_clr = 1'b1;
    for (int i = 0; i < NB; i++) tras_clr = tras_clr & (tras[i] == '0);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      ccd_cnt      <= '0;
      ref_cnt      <= FW'(TREFI);
      ref_pending  <= 1'b0;
      run          <= 1'b0;
      open_bank    <= '0;
      for (int i = 0; i < NB; i++) tras[i] <= '0;
      bus.cs_n     <= 1'b1;
      bus.act_n    <= 1'b1;
      bus.A        <= '1;
      bus.bg       <= '0;
      bus.ba       <= '0;
      bus.cmd_done <= 1'b0;
    end else begin
      run          <= 1'b1;
      bus.cs_n     <= 1'b1;
      bus.act_n    <= 1'b1;
      bus.A        <= '1;
      bus.bg       <= '0;
      bus.ba       <= '0;
      bus.cmd_done <= 1'b0;
      wait_cnt     <= wait_cnt - WW'(wait_cnt != '0);
      ccd_cnt      <= ccd_cnt - CW'(ccd_cnt != '0);
      for (int i = 0; i < NB; i++) tras[i] <= tras[i] - RW'(tras[i] != '0);
      case (state)
        S_IDLE:
          if (ref_pending) state <= S_RPREA;
          else if (accept) begin
            r_we  <= bus.req_we;
            r_bg  <= bus.req_bg;
            r_ba  <= bus.req_ba;
            r_row <= bus.req_row;
            r_col <= bus.req_col;
            state <= !open_bank[rbk] ? S_ACT : row_tab[rbk] == bus.req_row ? S_COL : S_PRE;
          end
        S_PRE:
          if (!bus.stall && tras[bk] == '0) begin
            bus.cs_n      <= 1'b0;
            bus.A         <= A_PRE;
            bus.bg        <= r_bg;
            bus.ba        <= r_ba;
            open_bank[bk] <= 1'b0;
            wait_cnt      <= WW'(TRP - 1);
            state         <= S_WAIT_RP;
          end
        S_WAIT_RP: if (wait_cnt <= WW'(1)) state <= S_ACT;
        S_ACT:
          if (!bus.stall) begin
            bus.cs_n      <= 1'b0;
            bus.act_n     <= 1'b0;
            bus.A         <= r_row;
            bus.bg        <= r_bg;
            bus.ba        <= r_ba;
            open_bank[bk] <= 1'b1;
            row_tab[bk]   <= r_row;
            tras[bk]      <= RW'(TRAS - 1);
            wait_cnt      <= WW'(TRCD - 1);
            state         <= S_WAIT_RCD;
          end
        S_WAIT_RCD: if (wait_cnt <= WW'(1)) state <= S_COL;
        S_COL:
          if (!bus.stall && ccd_cnt == '0) begin
            bus.cs_n     <= 1'b0;
            bus.A        <= (r_we ? A_WR : A_RD) | ADDRWIDTH'(r_col);
            bus.bg       <= r_bg;
            bus.ba       <= r_ba;
            bus.cmd_done <= 1'b1;
            ccd_cnt      <= CW'(TCCD - 1);
            state        <= S_IDLE;
          end
        S_RPREA:
          if (open_bank == '0) state <= S_RREF;
          else if (!bus.stall && tras_clr) begin
            bus.cs_n  <= 1'b0;
            bus.A     <= A_PREA;
            open_bank <= '0;
            wait_cnt  <= WW'(TRP - 1);
            state     <= S_RWAIT_RP;
          end
        S_RWAIT_RP: if (wait_cnt <= WW'(1)) state <= S_RREF;
        S_RREF:
          if (!bus.stall) begin
            bus.cs_n    <= 1'b0;
            bus.A       <= A_REF;
            ref_pending <= 1'b0;
            wait_cnt    <= WW'(TRFC - 1);
            state       <= S_WAIT_RFC;
          end
        S_WAIT_RFC: if (wait_cnt <= WW'(1)) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // placed after the FSM so a refresh coming due in the REF cycle is not lost
      ref_cnt <= ref_cnt == '0 ? FW'(TREFI) : ref_cnt - 1'b1;
      if (ref_cnt == '0) ref_pending <= 1'b1;
    end
  end
endmodule
